// File: rtl/mux_4_1_rr_arbiter.sv
// Four-requester arbiter sharing one 4:1 mux, feeding a registered valid/ready output stage.
// Build option: define MUX_ARB_FIXED_PRIORITY_EN for fixed priority (0 highest); default is round-robin.
module mux_4_1_rr_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data [0:3],
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic [1:0]   out_sel_q,   out_sel_d;

  logic       any_valid;
  logic       slot_free;
  logic       capture;
  logic [1:0] win;

  assign any_valid = |in_valid;
  assign slot_free = !out_valid_q || out_ready;
  assign capture   = slot_free && any_valid && !rst;

`ifdef MUX_ARB_FIXED_PRIORITY_EN
  // Descending scan so the lowest valid index is the last assignment and wins.
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[k]) begin
        win = 2'(k);
      end
    end
  end
`else
  logic [1:0] last_grant_q, last_grant_d;

  // Candidate k is last_grant+1+k (mod 4); scanning k downward leaves the
  // nearest valid requester after last_grant as the winner.
  always_comb begin
    logic [1:0] cand;
    win  = 2'd0;
    cand = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = last_grant_q + 2'd1 + 2'(k);
      if (in_valid[cand]) begin
        win = cand;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (capture) begin
      last_grant_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 2'd3;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ready
      assign in_ready[gi] = capture && (win == 2'(gi));
    end
  endgenerate

  // Only the granted word is muxed in, so X on idle requesters never propagates.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[win];
      out_sel_d   = win;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_mux_4_1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid;
  logic [3:0] in_data [0:3];
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  mux_4_1_rr_arbiter #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit         m_ov;
  logic [3:0] m_od;
  int         m_os;
  int         m_lg;
  logic [3:0] last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int m_win(input logic [3:0] v, input int lg);
`ifdef MUX_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (v[(lg + k) % 4]) return (lg + k) % 4;
`endif
    return -1;
  endfunction

  // One clock: check grant before the edge, advance the model, check the registers after it.
  task automatic cycle();
    int w;
    bit sf;
    logic [3:0] exp_rdy;
    #2;
    sf = !m_ov || out_ready;
    w  = m_win(in_valid, m_lg);
    exp_rdy = 4'b0000;
    if (!rst && sf && w >= 0) exp_rdy[w] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (rst) begin
      m_ov = 0; m_od = 4'h0; m_os = 0; m_lg = 3;
    end else if (sf && w >= 0) begin
      m_ov = 1; m_od = in_data[w]; m_os = w; m_lg = w;
      $display("xfer req=%0d data=%h", w, in_data[w]);
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    last_acc = exp_rdy;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("out_sel",   32'(out_sel),   32'(m_os));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 4'b0000;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = 4'h0;
    m_ov = 0; m_od = 4'h0; m_os = 0; m_lg = 3; last_acc = 4'b0000;
    @(posedge clk); #1;
    do_reset();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data",  32'(out_data),  32'd0);

    // Single requester
    in_valid = 4'b0100; in_data[2] = 4'h7; out_ready = 1'b1;
    #2;
    check("single_rdy", 32'(in_ready), 32'h4);
    cycle();
    check("single_val", 32'(out_valid), 32'd1);
    check("single_dat", 32'(out_data),  32'h7);
    check("single_sel", 32'(out_sel),   32'd2);

    // Full load
    do_reset();
    in_data[0] = 4'ha; in_data[1] = 4'hb; in_data[2] = 4'hc; in_data[3] = 4'hd;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("full_val", 32'(out_valid), 32'd1);
`ifndef MUX_ARB_FIXED_PRIORITY_EN
      check("full_sel", 32'(out_sel), 32'(n % 4));
      check("full_dat", 32'(out_data), 32'(4'ha + 4'(n % 4)));
`else
      check("fixed_sel", 32'(out_sel), 32'd0);
`endif
    end

    // Backpressure: word a held for three cycles
    do_reset();
    in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #2;
      check("bp_rdy", 32'(in_ready), 32'h0);
      cycle();
      check("bp_dat", 32'(out_data), 32'ha);
      check("bp_sel", 32'(out_sel), 32'd0);
    end
    out_ready = 1'b1;
`ifndef MUX_ARB_FIXED_PRIORITY_EN
    #2;
    check("bp_release_rdy", 32'(in_ready), 32'h2);
    cycle();
    check("bp_release_dat", 32'(out_data), 32'hb);
`else
    cycle();
`endif

    // Rotation skip: grant 1 first, then pattern 1010
    do_reset();
    in_valid = 4'b0010;
    cycle();
    in_valid = 4'b1010;
    cycle();
`ifndef MUX_ARB_FIXED_PRIORITY_EN
    check("skip_first", 32'(out_sel), 32'd3);
`endif
    cycle();
    check("skip_second", 32'(out_sel), 32'd1);

    // Reset mid-operation while stalled
    in_valid = 4'b1111; out_ready = 1'b0;
    cycle();
    check("mid_held", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #2;
    check("mid_rst_rdy", 32'(in_ready), 32'h0);
    cycle();
    check("mid_dropped", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    cycle();
    check("mid_restart", 32'(out_sel), 32'd0);

    // Randomized traffic; requesters hold words until accepted
    in_valid = 4'b0000;
    last_acc = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!in_valid[i] || last_acc[i]) begin
          in_valid[i] = ($urandom_range(0, 99) < 60);
          in_data[i]  = 4'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 99) < 2);
      cycle();
      if (rst) in_valid = 4'b0000;
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
